rhs_spi_responder: RTL and testbench

- Synthesizable, clk-domain emulator of one RHS2116 stimulation/recording chip on the SPI slave side of the rhs_256 master.
- Decodes 32-bit MOSI commands: CONVERT, READ, WRITE and CLEAR.
- Returns MISO results with the chip's two-frame pipeline latency.
- Used for FPGA loopback of the 16-port front end and as a cycle-accurate bench target for rhs_256.

---
 rtl/rhs_spi_responder.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_rhs_spi_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhs_spi_responder.sv
// -----------------------------------------------------------------------------
// rhs_spi_responder
// Clock-domain emulator of one RHS2116 chip on the SPI slave side. Decodes
// 32-bit CONVERT / READ / WRITE / CLEAR commands and returns each result two
// frames later, matching the chip's pipeline latency.
//
// Parameters:
//   STARTING_SEED  base value for generated sample data (typically 16*port)
//   CHIP_ID        value returned from ROM register 255
//
// Ports:
//   clk         system clock, at least 4x SCLK
//   rstn        asynchronous active-low reset
//   SCLK        SPI clock from master, idle low (asynchronous to clk)
//   CS          active-low frame select (asynchronous to clk)
//   MOSI        command bit, MSB first, sampled on SCLK rising
//   MISO        result bit, MSB first, changes on SCLK falling
//   channel     channel field of the most recent accepted CONVERT
//   frame_done  one-clk pulse per accepted 32-bit frame
//
// Optional build macro RHS_RESP_FRAME_CHECK_EN adds:
//   frame_err   sticky flag, set on every aborted frame
//   err_count   count of aborted frames, saturating at 255
// -----------------------------------------------------------------------------
module rhs_spi_responder #(
    parameter int unsigned STARTING_SEED = 0,
    parameter logic [15:0] CHIP_ID       = 16'h0020
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SCLK,
    input  logic       CS,
    input  logic       MOSI,
    output logic       MISO,
    output logic [7:0] channel,
    output logic       frame_done
`ifdef RHS_RESP_FRAME_CHECK_EN
    ,
    output logic       frame_err,
    output logic [7:0] err_count
`endif
);

    localparam int unsigned W_CMD    = 32;
    localparam int unsigned W_DATA   = 16;
    localparam int unsigned N_REG    = 32;
    localparam int unsigned N_CNT    = 16;
    localparam int unsigned W_CNT    = 8;
    localparam int unsigned W_BITCNT = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    // ---------------------------------------------------------------- state
    logic [1:0]                         state_q,  state_d;
    logic [1:0]                         sclk_sync_q, sclk_sync_d;
    logic [1:0]                         cs_sync_q,   cs_sync_d;
    logic [1:0]                         mosi_sync_q, mosi_sync_d;
    logic                               sclk_prev_q, sclk_prev_d;
    logic                               cs_prev_q,   cs_prev_d;
    logic                               cs_pend_q,   cs_pend_d;
    logic [W_CMD-1:0]                   rx_shift_q,  rx_shift_d;
    logic [W_CMD-1:0]                   tx_shift_q,  tx_shift_d;
    logic [W_BITCNT-1:0]                bitcnt_q,    bitcnt_d;
    logic [W_CMD-1:0]                   r1_q,        r1_d;
    logic [W_CMD-1:0]                   r2_q,        r2_d;
    logic [N_REG-1:0][W_DATA-1:0]       regs_q,      regs_d;
    logic [N_CNT-1:0][W_CNT-1:0]        cnt_q,       cnt_d;
    logic                               miso_q,      miso_d;
    logic [7:0]                         channel_q,   channel_d;
    logic                               frame_done_q, frame_done_d;
`ifdef RHS_RESP_FRAME_CHECK_EN
    logic                               frame_err_q, frame_err_d;
    logic [7:0]                         err_count_q, err_count_d;
`endif

    // Synchronised inputs and edge strobes
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_rise   =  cs_s   & ~cs_prev_q;
    assign cs_fall   = ~cs_s   &  cs_prev_q;

    // Two-flop synchronisers and edge-detect history
    always_comb begin : sync_c
        sclk_sync_d = {sclk_sync_q[0], SCLK};
        cs_sync_d   = {cs_sync_q[0],   CS};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // ------------------------------------------------------- command decode
    logic [1:0]        cmd_op;
    logic [5:0]        cmd_ch;
    logic [7:0]        cmd_addr;
    logic [W_DATA-1:0] cmd_data;
    logic [9:0]        seed_sum;
    logic [W_DATA-1:0] read_val;
    logic [W_CMD-1:0]  result;
    logic              conv_any;
    logic              conv_hit;
    logic              wr_hit;
    logic              clr_hit;

    assign cmd_op   = rx_shift_q[31:30];
    assign cmd_ch   = rx_shift_q[21:16];
    assign cmd_addr = rx_shift_q[23:16];
    assign cmd_data = rx_shift_q[15:0];

    // ROM / register-file read mux
    always_comb begin : read_mux_c
        read_val = '0;
        if (cmd_addr < 8'(N_REG)) begin
            read_val = regs_q[cmd_addr[4:0]];
        end else begin
            case (cmd_addr)
                8'd251:  read_val = 16'h0049;
                8'd252:  read_val = 16'h004E;
                8'd253:  read_val = 16'h0054;
                8'd254:  read_val = 16'h0041;
                8'd255:  read_val = CHIP_ID;
                default: read_val = '0;
            endcase
        end
    end

    // Result word and side-effect strobes for the received command
    always_comb begin : decode_c
        result   = '0;
        conv_any = 1'b0;
        conv_hit = 1'b0;
        wr_hit   = 1'b0;
        clr_hit  = 1'b0;
        // Sum kept at 10 bits: the dc field is defined modulo 1024
        seed_sum = 10'(STARTING_SEED) + 10'(cmd_ch);
        case (cmd_op)
            2'b00: begin
                conv_any = 1'b1;
                if (cmd_ch < 6'(N_CNT)) begin
                    conv_hit = 1'b1;
                    result   = {6'b0, seed_sum, seed_sum[7:0], cnt_q[cmd_ch[3:0]]};
                end
            end
            2'b10: begin
                wr_hit = (cmd_addr < 8'(N_REG));
                result = {16'hFFFF, cmd_data};
            end
            2'b11: begin
                result = {16'h0000, read_val};
            end
            default: begin
                clr_hit = (rx_shift_q[31:16] == 16'h6A00);
            end
        endcase
    end

    // ------------------------------------------------------- main FSM logic
    always_comb begin : next_state_c
        state_d      = state_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        bitcnt_d     = bitcnt_q;
        miso_d       = miso_q;
        channel_d    = channel_q;
        frame_done_d = 1'b0;
        r1_d         = r1_q;
        r2_d         = r2_q;
        regs_d       = regs_q;
        cnt_d        = cnt_q;
        cs_pend_d    = cs_pend_q;
`ifdef RHS_RESP_FRAME_CHECK_EN
        frame_err_d  = frame_err_q;
        err_count_d  = err_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cs_pend_d = 1'b0;
                // A fall held over from DECODE/ABORT only counts if CS is still low
                if ((cs_fall || cs_pend_q) && !cs_s) begin
                    tx_shift_d = r2_q;
                    miso_d     = r2_q[31];
                    rx_shift_d = '0;
                    bitcnt_d   = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    // CS rise wins over any SCLK edge seen in the same clk
                    state_d = (bitcnt_q == W_BITCNT'(W_CMD)) ? ST_DECODE : ST_ABORT;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[30:0], mosi_s};
                        // Saturate so an over-long frame never wraps back to 32
                        if (bitcnt_q != '1) begin
                            bitcnt_d = bitcnt_q + W_BITCNT'(1);
                        end
                    end
                    if (sclk_fall) begin
                        tx_shift_d = {tx_shift_q[30:0], 1'b0};
                        miso_d     = tx_shift_q[30];
                    end
                end
            end
            ST_DECODE: begin
                if (conv_any) begin
                    channel_d = {2'b00, cmd_ch};
                end
                if (conv_hit) begin
                    cnt_d[cmd_ch[3:0]] = cnt_q[cmd_ch[3:0]] + W_CNT'(1);
                end
                if (wr_hit) begin
                    regs_d[cmd_addr[4:0]] = cmd_data;
                end
                if (clr_hit) begin
                    cnt_d = '0;
                end
                r2_d         = r1_q;
                r1_d         = result;
                frame_done_d = 1'b1;
                cs_pend_d    = cs_fall;
                state_d      = ST_IDLE;
            end
            default: begin
                // ST_ABORT: frame dropped, queue left untouched
                cs_pend_d = cs_fall;
                state_d   = ST_IDLE;
`ifdef RHS_RESP_FRAME_CHECK_EN
                frame_err_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
`endif
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rstn) begin : regs_ff
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            cs_pend_q    <= 1'b0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            bitcnt_q     <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            regs_q       <= '0;
            cnt_q        <= '0;
            miso_q       <= 1'b0;
            channel_q    <= '0;
            frame_done_q <= 1'b0;
`ifdef RHS_RESP_FRAME_CHECK_EN
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            cs_pend_q    <= cs_pend_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            bitcnt_q     <= bitcnt_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            regs_q       <= regs_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            channel_q    <= channel_d;
            frame_done_q <= frame_done_d;
`ifdef RHS_RESP_FRAME_CHECK_EN
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
`endif
        end
    end

    assign MISO       = miso_q;
    assign channel    = channel_q;
    assign frame_done = frame_done_q;
`ifdef RHS_RESP_FRAME_CHECK_EN
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_rhs_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_rhs_spi_responder
// Directed bench for rhs_spi_responder (STARTING_SEED = 16). Drives SPI frames
// from a behavioural master and compares returned MISO words, channel and
// frame_done activity against hand-computed values.
// -----------------------------------------------------------------------------
module tb_rhs_spi_responder;

    logic       clk;
    logic       rstn;
    logic       SCLK;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    logic [7:0] channel;
    logic       frame_done;
`ifdef RHS_RESP_FRAME_CHECK_EN
    logic       frame_err;
    logic [7:0] err_count;
`endif

    int n_cmp;
    int n_err;
    int fd_cnt;

    rhs_spi_responder #(
        .STARTING_SEED(16),
        .CHIP_ID      (16'h0020)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .SCLK      (SCLK),
        .CS        (CS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .channel   (channel),
        .frame_done(frame_done)
`ifdef RHS_RESP_FRAME_CHECK_EN
        ,
        .frame_err (frame_err),
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // frame_done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    function automatic logic [31:0] rd(input logic [7:0] addr);
        return {2'b11, 6'b0, addr, 16'h0000};
    endfunction

    function automatic logic [31:0] wr(input logic [7:0] addr, input logic [15:0] data);
        return {2'b10, 6'b0, addr, data};
    endfunction

    function automatic logic [31:0] cv(input logic [5:0] ch);
        return {10'b0, ch, 16'h0000};
    endfunction

    // SPI master: SCLK half period 30 ns, MISO captured just before each rise
    task automatic spi_frame(input logic [31:0] mosi_w, input int nbits,
                             output logic [31:0] miso_w);
        logic [31:0] sh;
        sh     = mosi_w;
        miso_w = '0;
        @(negedge clk);
        CS   = 1'b0;
        MOSI = sh[31];
        #30;
        for (int i = 0; i < nbits; i++) begin
            miso_w = {miso_w[30:0], MISO};
            SCLK   = 1'b1;
            #30;
            SCLK   = 1'b0;
            sh     = {sh[30:0], 1'b0};
            MOSI   = sh[31];
            #30;
        end
        CS = 1'b1;
        #60;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        #47;
        n_cmp++;
        if (MISO !== 1'b0) begin
            n_err++; $display("FAIL reset_miso: got %b expected 0", MISO);
        end
        n_cmp++;
        if (channel !== 8'd0) begin
            n_err++; $display("FAIL reset_channel: got %0d expected 0", channel);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_err++; $display("FAIL reset_frame_done: got %b expected 0", frame_done);
        end
        @(negedge clk);
        rstn = 1'b1;
        #50;
`ifdef RHS_RESP_FRAME_CHECK_EN
        n_cmp++;
        if (frame_err !== 1'b0 || err_count !== 8'd0) begin
            n_err++; $display("FAIL reset_err: got %b/%0d expected 0/0", frame_err, err_count);
        end
`endif
    endtask

    task automatic test_rom_read();
        logic [31:0] cmds[4];
        logic [31:0] exp[4];
        logic [31:0] got;
        int fd0;
        cmds = '{rd(8'd255), rd(8'd251), rd(8'd0), rd(8'd0)};
        exp  = '{32'h0, 32'h0, 32'h00000020, 32'h00000049};
        fd0  = fd_cnt;
        for (int i = 0; i < 4; i++) begin
            spi_frame(cmds[i], 32, got);
            n_cmp++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL rom_read[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
        n_cmp++;
        if (fd_cnt - fd0 !== 4) begin
            n_err++; $display("FAIL rom_frame_done: got %0d expected 4", fd_cnt - fd0);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] cmds[4];
        logic [31:0] exp[4];
        logic [31:0] got;
        cmds = '{wr(8'd5, 16'hBEEF), rd(8'd5), cv(6'd0), cv(6'd0)};
        exp  = '{32'h0, 32'h0, 32'hFFFFBEEF, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            spi_frame(cmds[i], 32, got);
            n_cmp++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL write_read[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_convert();
        logic [31:0] exp[6];
        logic [31:0] got;
        // seed 16+0 -> 0x00101000 | cnt ; seed 16+3 -> 0x00131300 | cnt
        exp = '{32'h00101000, 32'h00101001, 32'h00131300,
                32'h00131301, 32'h00131302, 32'h00131303};
        for (int i = 0; i < 6; i++) begin
            spi_frame(cv(6'd3), 32, got);
            n_cmp++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL convert_ch3[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
        n_cmp++;
        if (channel !== 8'd3) begin
            n_err++; $display("FAIL convert_channel: got %0d expected 3", channel);
        end
    endtask

    task automatic test_convert_high();
        logic [31:0] cmds[5];
        logic [31:0] exp[5];
        logic [31:0] got;
        cmds = '{cv(6'd20), cv(6'd3), cv(6'd3), cv(6'd3), cv(6'd3)};
        exp  = '{32'h00131304, 32'h00131305, 32'h0, 32'h00131306, 32'h00131307};
        for (int i = 0; i < 5; i++) begin
            spi_frame(cmds[i], 32, got);
            n_cmp++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL convert_high[%0d]: got %h expected %h", i, got, exp[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (channel !== 8'd20) begin
                    n_err++; $display("FAIL channel_20: got %0d expected 20", channel);
                end
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] cmds[5];
        logic [31:0] exp[5];
        logic [31:0] got;
        cmds = '{32'h6A000000, cv(6'd3), 32'h40000000, rd(8'd255), rd(8'd255)};
        exp  = '{32'h00131308, 32'h00131309, 32'h0, 32'h00131300, 32'h0};
        for (int i = 0; i < 5; i++) begin
            spi_frame(cmds[i], 32, got);
            n_cmp++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL clear[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        logic [31:0] exp;
        spi_frame(32'h6A000000, 32, got);
        n_cmp++;
        if (got !== 32'h00000020) begin
            n_err++; $display("FAIL wrap_clear: got %h expected 00000020", got);
        end
        for (int j = 1; j <= 260; j++) begin
            spi_frame(cv(6'd0), 32, got);
            if (j == 1)      exp = 32'h00000020;
            else if (j == 2) exp = 32'h0;
            else             exp = 32'h00101000 | 32'((j - 3) % 256);
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL wrap[%0d]: got %h expected %h", j, got, exp);
            end
            // frame 259 carries the 257th conversion: counter back at zero
            if (j == 259) begin
                n_cmp++;
                if (got[7:0] !== 8'h00) begin
                    n_err++; $display("FAIL wrap_257_ac: got %h expected 00", got[7:0]);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] got;
        int fd0;
        fd0 = fd_cnt;
        spi_frame(rd(8'd255), 17, got);
        n_cmp++;
        if (got !== (32'h00101002 >> 15)) begin
            n_err++; $display("FAIL abort_partial: got %h expected %h", got, 32'h00101002 >> 15);
        end
        n_cmp++;
        if (fd_cnt !== fd0) begin
            n_err++; $display("FAIL abort_frame_done: got %0d expected %0d", fd_cnt, fd0);
        end
`ifdef RHS_RESP_FRAME_CHECK_EN
        n_cmp++;
        if (frame_err !== 1'b1 || err_count !== 8'd1) begin
            n_err++; $display("FAIL abort_err: got %b/%0d expected 1/1", frame_err, err_count);
        end
`endif
        spi_frame(rd(8'd255), 32, got);
        n_cmp++;
        if (got !== 32'h00101002) begin
            n_err++; $display("FAIL abort_next0: got %h expected 00101002", got);
        end
        spi_frame(rd(8'd255), 32, got);
        n_cmp++;
        if (got !== 32'h00101003) begin
            n_err++; $display("FAIL abort_next1: got %h expected 00101003", got);
        end
        n_cmp++;
        if (fd_cnt - fd0 !== 2) begin
            n_err++; $display("FAIL abort_fd_total: got %0d expected 2", fd_cnt - fd0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] got;
        logic [31:0] sh;
        logic [31:0] cmds[4];
        spi_frame(wr(8'd2, 16'hABCD), 32, got);
        n_cmp++;
        if (got !== 32'h00000020) begin
            n_err++; $display("FAIL pre_write: got %h expected 00000020", got);
        end
        // Start WRITE 2 0x1234 and pull rstn after bit 12
        sh = wr(8'd2, 16'h1234);
        @(negedge clk);
        CS   = 1'b0;
        MOSI = sh[31];
        #30;
        for (int i = 0; i < 12; i++) begin
            SCLK = 1'b1;
            #30;
            SCLK = 1'b0;
            sh   = {sh[30:0], 1'b0};
            MOSI = sh[31];
            #30;
        end
        rstn = 1'b0;
        #20;
        n_cmp++;
        if (MISO !== 1'b0) begin
            n_err++; $display("FAIL midreset_miso: got %b expected 0", MISO);
        end
        n_cmp++;
        if (channel !== 8'd0) begin
            n_err++; $display("FAIL midreset_channel: got %0d expected 0", channel);
        end
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        #50;
        rstn = 1'b1;
        #50;
        cmds = '{rd(8'd2), rd(8'd2), rd(8'd255), rd(8'd255)};
        for (int i = 0; i < 4; i++) begin
            spi_frame(cmds[i], 32, got);
            n_cmp++;
            if (got !== 32'h0) begin
                n_err++; $display("FAIL midreset_read[%0d]: got %h expected 00000000", i, got);
            end
        end
`ifdef RHS_RESP_FRAME_CHECK_EN
        n_cmp++;
        if (frame_err !== 1'b0 || err_count !== 8'd0) begin
            n_err++; $display("FAIL midreset_err: got %b/%0d expected 0/0", frame_err, err_count);
        end
`endif
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        fd_cnt = 0;
        test_reset();
        test_rom_read();
        test_write_read();
        test_convert();
        test_convert_high();
        test_clear();
        test_wrap();
        test_abort();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
